// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, reset vector, NOP encoding and the
// fetch-control state type used by the instruction-fetch stage.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_RUN,
        FETCH_TRAP,
        FETCH_HALT
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous fetch queue: DEPTH entries (power of two), push/pop/flush,
// full/empty derived from read/write pointers carrying one extra wrap bit.
module if_fifo import core_pkg::*; #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch queue toward decode, redirects.
// Define IF_MISALIGN_TRAP_EN to turn misaligned redirects into a faulting entry.
module if_stage import core_pkg::*; #(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            id_fault
);

`ifdef IF_MISALIGN_TRAP_EN
    localparam int unsigned ENTRY_W = XLEN + ILEN + 1;
`else
    localparam int unsigned ENTRY_W = XLEN + ILEN;
`endif

    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    redirect_tgt;
    logic               fetch_en;
    logic               advance;
    logic               fq_push, fq_pop, fq_full, fq_empty;
    logic [ENTRY_W-1:0] fq_wdata, fq_rdata;

    assign imem_addr = pc_q;
    assign id_valid  = !fq_empty;
    assign fq_pop    = id_valid && id_ready;
    // A full queue still accepts a push when decode drains the head this cycle.
    assign fq_push   = fetch_en && !redirect_valid && (!fq_full || fq_pop);

`ifdef IF_MISALIGN_TRAP_EN
    fetch_state_e state_q, state_d;

    assign redirect_tgt = redirect_pc;

    always_comb begin
        state_d  = state_q;
        fetch_en = 1'b1;
        advance  = 1'b1;
        fq_wdata = {1'b0, pc_q, imem_inst};
        unique case (state_q)
            FETCH_RUN: ;
            FETCH_TRAP: begin
                advance  = 1'b0;
                fq_wdata = {1'b1, pc_q, NOP_INST};
                if (!fq_full) state_d = FETCH_HALT;
            end
            FETCH_HALT: begin
                fetch_en = 1'b0;
                advance  = 1'b0;
            end
            default: state_d = FETCH_RUN;
        endcase
        if (redirect_valid) state_d = is_misaligned(redirect_pc) ? FETCH_TRAP : FETCH_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH_RUN;
        else     state_q <= state_d;
    end

    assign id_fault = id_valid & fq_rdata[ENTRY_W-1];
`else
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_en     = 1'b1;
    assign advance      = 1'b1;
    assign fq_wdata     = {pc_q, imem_inst};
    assign id_fault     = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)         pc_d = redirect_tgt;
        else if (fq_push && advance) pc_d = pc_q + 32'd4;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    if_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fq_push),
        .pop_i   (fq_pop),
        .flush_i (redirect_valid),
        .wdata_i (fq_wdata),
        .rdata_o (fq_rdata),
        .full_o  (fq_full),
        .empty_o (fq_empty)
    );

    assign id_pc   = id_valid ? fq_rdata[ILEN +: XLEN] : '0;
    assign id_inst = id_valid ? fq_rdata[ILEN-1:0]     : '0;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a negedge monitor pops an expected-entry
// scoreboard on every decode handshake; scenario tasks add inline checks.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_fault;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_inst = mem_word(imem_addr);

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_fault       (id_fault)
    );

    // Scoreboard monitor: every accepted head entry must match the next expected one.
    always @(negedge clk) begin
        if (!rst && id_valid && id_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pop: got pc=%h inst=%h, required no entry", id_pc, id_inst);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (id_pc !== e.pc || id_inst !== e.inst || id_fault !== e.fault) begin
                    miscompares++;
                    $display("FAIL pop_entry: got pc=%h inst=%h fault=%b, required pc=%h inst=%h fault=%b",
                             id_pc, id_inst, id_fault, e.pc, e.inst, e.fault);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        sb.push_back('{pc, mem_word(pc), 1'b0});
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drained: got %0d entries outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h0 || id_pc !== 32'h0 ||
            id_inst !== 32'h0 || id_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b addr=%h pc=%h inst=%h fault=%b, required 0/0/0/0/0",
                     id_valid, imem_addr, id_pc, id_inst, id_fault);
        end
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
        id_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            vectors++;
            if (id_valid !== 1'b1 || imem_addr !== 32'(i * 4)) begin
                miscompares++;
                $display("FAIL stream_cycle%0d: got valid=%b addr=%h, required 1/%h",
                         i, id_valid, imem_addr, 32'(i * 4));
            end
        end
        id_ready = 1'b0;
        check_drained("reset_stream");
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i >= 2) begin
                vectors++;
                if (imem_addr !== 32'h8 || id_valid !== 1'b1 || id_pc !== 32'h0 ||
                    id_inst !== mem_word(32'h0)) begin
                    miscompares++;
                    $display("FAIL stall_cycle%0d: got addr=%h valid=%b pc=%h inst=%h, required 8/1/0/%h",
                             i, imem_addr, id_valid, id_pc, id_inst, mem_word(32'h0));
                end
            end
        end
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        id_ready = 1'b1;
        repeat (3) tick();
        id_ready = 1'b0;
        check_drained("backpressure");
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        push_exp(32'h100);
        push_exp(32'h104);
        tick();
        redirect_valid = 1'b0;
        vectors++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_flush: got valid=%b addr=%h, required 0/00000100", id_valid, imem_addr);
        end
        tick();
        vectors++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_first: got valid=%b pc=%h, required 1/00000100", id_valid, id_pc);
        end
        id_ready = 1'b1;
        repeat (2) tick();
        id_ready = 1'b0;
        check_drained("redirect");
    endtask

    task automatic test_simultaneous();
        do_reset();
        repeat (2) tick();
        push_exp(32'h0);
        push_exp(32'h200);
        push_exp(32'h204);
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        vectors++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL simul_empty: got valid=%b addr=%h, required 0/00000200", id_valid, imem_addr);
        end
        repeat (3) tick();
        id_ready = 1'b0;
        check_drained("simultaneous");
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        tick();
        vectors++;
        if (imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_addr: got %h, required 00000000", imem_addr);
        end
        repeat (2) tick();
        id_ready = 1'b0;
        check_drained("wrap");
    endtask

    task automatic test_random_ready();
        int consumed;
        do_reset();
        for (int i = 0; i < 64; i++) push_exp(32'(i * 4));
        for (int i = 0; i < 60; i++) begin
            id_ready = 1'($urandom_range(0, 1));
            tick();
        end
        id_ready = 1'b0;
        consumed = 64 - sb.size();
        vectors++;
        if (consumed < 10) begin
            miscompares++;
            $display("FAIL random_progress: got %0d entries consumed, required at least 10", consumed);
        end
        sb.delete();
    endtask

    task automatic test_midstream_reset();
        id_ready       = 1'b0;
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        vectors++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h0 || id_pc !== 32'h0 ||
            id_inst !== 32'h0 || id_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: got valid=%b addr=%h pc=%h inst=%h fault=%b, required 0/0/0/0/0",
                     id_valid, imem_addr, id_pc, id_inst, id_fault);
        end
    endtask

`ifdef IF_MISALIGN_TRAP_EN
    task automatic test_misalign();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        sb.push_back('{32'h102, NOP, 1'b1});
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        vectors++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h102) begin
            miscompares++;
            $display("FAIL trap_flush: got valid=%b addr=%h, required 0/00000102", id_valid, imem_addr);
        end
        tick();
        vectors++;
        if (id_valid !== 1'b1 || id_fault !== 1'b1 || id_inst !== NOP || id_pc !== 32'h102) begin
            miscompares++;
            $display("FAIL trap_entry: got valid=%b fault=%b inst=%h pc=%h, required 1/1/00000013/00000102",
                     id_valid, id_fault, id_inst, id_pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (id_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL trap_frozen%0d: got valid=%b, required 0", i, id_valid);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        push_exp(32'h200);
        tick();
        redirect_valid = 1'b0;
        tick();
        vectors++;
        if (id_pc !== 32'h200 || id_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_resume: got pc=%h fault=%b, required 00000200/0", id_pc, id_fault);
        end
        tick();
        id_ready = 1'b0;
        check_drained("misalign");
    endtask
`else
    task automatic test_misalign();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        push_exp(32'h100);
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        vectors++;
        if (imem_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL align_force: got addr=%h, required 00000100", imem_addr);
        end
        repeat (2) tick();
        id_ready = 1'b0;
        check_drained("misalign");
    endtask
`endif

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        test_reset();
        test_backpressure();
        test_redirect();
        test_simultaneous();
        test_wrap();
        test_random_ready();
        test_midstream_reset();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
